// File: rtl/mem_ctrl_pkg.sv
// rtl/mem_ctrl_pkg.sv - shared types and constants for the memory access controller
package mem_ctrl_pkg;

    localparam int DEF_ADDR_W      = 16;
    localparam int DEF_DATA_W      = 16;
    localparam int DEF_WAIT_CYCLES = 2;
    localparam int DEF_CNT_W       = 4;

    // Grant identifiers; also the encoding of the arbiter's last-grant register
    localparam logic GNT_IF = 1'b0;
    localparam logic GNT_DM = 1'b1;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ADDR = 3'd1,
        WAIT = 3'd2,
        XFER = 3'd3,
        ACK  = 3'd4
    } state_e;

endpackage

// File: rtl/mem_rr_arbiter.sv
// rtl/mem_rr_arbiter.sv - two-way round-robin arbiter between fetch and data ports
module mem_rr_arbiter
    import mem_ctrl_pkg::*;
(
    input  logic clk_i,
    input  logic rst_ni,
    input  logic if_req_i,
    input  logic dm_req_i,
    input  logic eval_en_i,
    output logic gnt_valid_o,
    output logic gnt_id_o
);

    logic last_q;
    logic last_d;

    // Grant selection: a lone requester wins; on contention the port not granted last wins
    always_comb begin
        gnt_valid_o = eval_en_i & (if_req_i | dm_req_i);
        gnt_id_o    = GNT_IF;
        if (if_req_i && dm_req_i) begin
            gnt_id_o = (last_q == GNT_IF) ? GNT_DM : GNT_IF;
        end else if (dm_req_i) begin
            gnt_id_o = GNT_DM;
        end
        last_d = gnt_valid_o ? gnt_id_o : last_q;
    end

    // Last-grant history; reset to IF so the first contended grant goes to DM
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_q <= GNT_IF;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - sequencing controller and arbiter for the single-port RAM path
module mem_access_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int WAIT_CYCLES = DEF_WAIT_CYCLES,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              IF_REQ,
    input  logic [ADDR_W-1:0] IF_ADDR,
    output logic              IF_ACK,
    output logic [DATA_W-1:0] IF_RDATA,
    input  logic              DM_REQ,
    input  logic              DM_WE,
    input  logic [ADDR_W-1:0] DM_ADDR,
    input  logic [DATA_W-1:0] DM_WDATA,
    output logic              DM_ACK,
    output logic [DATA_W-1:0] DM_RDATA,
    output logic [ADDR_W-1:0] MAR,
    output logic [DATA_W-1:0] MDR,
    output logic              LDMAR,
    output logic              LDMDR,
    output logic              LDMEM,
    input  logic [DATA_W-1:0] MEM_RDATA,
    output logic              BUSY
);

    // Counter is loaded with one less than the wait length and leaves WAIT when it reads zero
    localparam logic [CNT_W-1:0] WAIT_LOAD =
        (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              gnt_q, gnt_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [ADDR_W-1:0] mar_q, mar_d;
    logic [DATA_W-1:0] mdr_q, mdr_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;

    logic arb_valid;
    logic arb_id;

    mem_rr_arbiter u_arb (
        .clk_i       (CLK),
        .rst_ni      (RST_N),
        .if_req_i    (IF_REQ),
        .dm_req_i    (DM_REQ),
        .eval_en_i   (state_q == IDLE),
        .gnt_valid_o (arb_valid),
        .gnt_id_o    (arb_id)
    );

    // Next-state, strobes and datapath register updates for the access sequence
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        gnt_d      = gnt_q;
        we_d       = we_q;
        wdata_d    = wdata_q;
        mar_d      = mar_q;
        mdr_d      = mdr_q;
        if_rdata_d = if_rdata_q;
        dm_rdata_d = dm_rdata_q;
        LDMAR      = 1'b0;
        LDMDR      = 1'b0;
        LDMEM      = 1'b0;
        IF_ACK     = 1'b0;
        DM_ACK     = 1'b0;

        case (state_q)
            IDLE: begin
                if (arb_valid) begin
                    gnt_d   = arb_id;
                    state_d = ADDR;
                    if (arb_id == GNT_DM) begin
                        mar_d   = DM_ADDR;
                        we_d    = DM_WE;
                        wdata_d = DM_WDATA;
                    end else begin
                        mar_d = IF_ADDR;
                        we_d  = 1'b0;
                    end
                end
            end
            ADDR: begin
                LDMAR = 1'b1;
                if (WAIT_CYCLES != 0) begin
                    state_d = WAIT;
                    cnt_d   = WAIT_LOAD;
                end else begin
                    state_d = XFER;
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = XFER;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            XFER: begin
                LDMDR = 1'b1;
                if (we_q) begin
                    LDMEM = 1'b1;
                end else if (gnt_q == GNT_DM) begin
                    dm_rdata_d = MEM_RDATA;
                end else begin
                    if_rdata_d = MEM_RDATA;
                end
                state_d = ACK;
            end
            ACK: begin
                IF_ACK  = (gnt_q == GNT_IF);
                DM_ACK  = (gnt_q == GNT_DM);
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // MDR picks up the write value as XFER is entered so it is valid alongside LDMEM
        if ((state_d == XFER) && (state_q != XFER) && we_q) begin
            mdr_d = wdata_q;
        end
    end

    // State, counter and datapath registers; reset aborts any transaction in flight
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            gnt_q      <= GNT_IF;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            mar_q      <= '0;
            mdr_q      <= '0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            gnt_q      <= gnt_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
            mar_q      <= mar_d;
            mdr_q      <= mdr_d;
            if_rdata_q <= if_rdata_d;
            dm_rdata_q <= dm_rdata_d;
        end
    end

    assign MAR      = mar_q;
    assign MDR      = mdr_q;
    assign IF_RDATA = if_rdata_q;
    assign DM_RDATA = dm_rdata_q;
    assign BUSY     = (state_q != IDLE);

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - directed self-checking bench for mem_access_ctrl
module tb_mem_access_ctrl;

    logic        CLK = 1'b0;
    logic        RST_N;

    logic        IF_REQ, DM_REQ, DM_WE;
    logic [15:0] IF_ADDR, DM_ADDR, DM_WDATA, MEM_RDATA;
    logic        IF_ACK, DM_ACK, LDMAR, LDMDR, LDMEM, BUSY;
    logic [15:0] IF_RDATA, DM_RDATA, MAR, MDR;

    logic        z_if_req, z_dm_req, z_dm_we;
    logic [15:0] z_if_addr, z_dm_addr, z_dm_wdata, z_mem_rdata;
    logic        z_if_ack, z_dm_ack, z_ldmar, z_ldmdr, z_ldmem, z_busy;
    logic [15:0] z_if_rdata, z_dm_rdata, z_mar, z_mdr;

    int n_cmp = 0;
    int n_err = 0;

    always #5 CLK = ~CLK;

    mem_access_ctrl #(.ADDR_W(16), .DATA_W(16), .WAIT_CYCLES(2), .CNT_W(4)) u_dut (
        .CLK(CLK), .RST_N(RST_N),
        .IF_REQ(IF_REQ), .IF_ADDR(IF_ADDR), .IF_ACK(IF_ACK), .IF_RDATA(IF_RDATA),
        .DM_REQ(DM_REQ), .DM_WE(DM_WE), .DM_ADDR(DM_ADDR), .DM_WDATA(DM_WDATA),
        .DM_ACK(DM_ACK), .DM_RDATA(DM_RDATA),
        .MAR(MAR), .MDR(MDR), .LDMAR(LDMAR), .LDMDR(LDMDR), .LDMEM(LDMEM),
        .MEM_RDATA(MEM_RDATA), .BUSY(BUSY)
    );

    mem_access_ctrl #(.ADDR_W(16), .DATA_W(16), .WAIT_CYCLES(0), .CNT_W(4)) u_dut_w0 (
        .CLK(CLK), .RST_N(RST_N),
        .IF_REQ(z_if_req), .IF_ADDR(z_if_addr), .IF_ACK(z_if_ack), .IF_RDATA(z_if_rdata),
        .DM_REQ(z_dm_req), .DM_WE(z_dm_we), .DM_ADDR(z_dm_addr), .DM_WDATA(z_dm_wdata),
        .DM_ACK(z_dm_ack), .DM_RDATA(z_dm_rdata),
        .MAR(z_mar), .MDR(z_mdr), .LDMAR(z_ldmar), .LDMDR(z_ldmdr), .LDMEM(z_ldmem),
        .MEM_RDATA(z_mem_rdata), .BUSY(z_busy)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    int ack_cnt;
    int ack_t [8];
    logic ack_p [8];
    int ldmem_seen;
    int dual_ack;

    initial begin
        RST_N = 1'b0;
        IF_REQ = 0; DM_REQ = 0; DM_WE = 0;
        IF_ADDR = 0; DM_ADDR = 0; DM_WDATA = 0; MEM_RDATA = 0;
        z_if_req = 0; z_dm_req = 0; z_dm_we = 0;
        z_if_addr = 0; z_dm_addr = 0; z_dm_wdata = 0; z_mem_rdata = 0;

        // reset state
        tick(); tick();
        chk("rst_busy", BUSY, 0);
        chk("rst_mar", MAR, 16'h0000);
        chk("rst_strobes", {LDMAR, LDMDR, LDMEM, IF_ACK, DM_ACK}, 5'b0);
        chk("rst_rdata", {IF_RDATA, DM_RDATA}, 32'h0);
        RST_N = 1'b1;

        // fetch read at 0x3000
        IF_REQ = 1; IF_ADDR = 16'h3000; MEM_RDATA = 16'h1234;
        tick();
        chk("if_ldmar", LDMAR, 1);
        chk("if_mar", MAR, 16'h3000);
        chk("if_busy", BUSY, 1);
        tick();
        chk("if_wait_strobes", {LDMAR, LDMDR, LDMEM}, 3'b000);
        tick();
        chk("if_wait2_strobes", {LDMAR, LDMDR, LDMEM}, 3'b000);
        tick();
        chk("if_xfer_ldmdr", LDMDR, 1);
        chk("if_xfer_ldmem", LDMEM, 0);
        chk("if_xfer_noack", IF_ACK, 0);
        tick();
        chk("if_ack", IF_ACK, 1);
        chk("if_ack_dm_quiet", DM_ACK, 0);
        chk("if_rdata", IF_RDATA, 16'h1234);
        IF_REQ = 0;
        tick();
        chk("if_ack_one_cycle", IF_ACK, 0);
        chk("if_idle", BUSY, 0);

        // data read to seed DM_RDATA
        DM_REQ = 1; DM_WE = 0; DM_ADDR = 16'h4000; MEM_RDATA = 16'h5A5A;
        repeat (5) tick();
        chk("dmr_ack", DM_ACK, 1);
        chk("dmr_rdata", DM_RDATA, 16'h5A5A);
        chk("dmr_if_rdata_held", IF_RDATA, 16'h1234);
        DM_REQ = 0;
        tick();

        // data write 0xBEEF to 0x4001; late data change is ignored
        DM_REQ = 1; DM_WE = 1; DM_ADDR = 16'h4001; DM_WDATA = 16'hBEEF; MEM_RDATA = 16'h0BAD;
        tick();
        chk("dmw_ldmar", LDMAR, 1);
        chk("dmw_mar", MAR, 16'h4001);
        DM_WDATA = 16'h1111; DM_ADDR = 16'h9999;
        repeat (3) tick();
        chk("dmw_xfer_strobes", {LDMDR, LDMEM}, 2'b11);
        chk("dmw_mdr", MDR, 16'hBEEF);
        chk("dmw_mar_held", MAR, 16'h4001);
        tick();
        chk("dmw_ack", DM_ACK, 1);
        chk("dmw_rdata_unchanged", DM_RDATA, 16'h5A5A);
        DM_REQ = 0; DM_WE = 0;
        tick();
        chk("dmw_mdr_hold", MDR, 16'hBEEF);
        chk("dmw_post_strobes", {LDMEM, DM_ACK, BUSY}, 3'b000);

        // abort a write in WAIT with an asynchronous reset
        DM_REQ = 1; DM_WE = 1; DM_ADDR = 16'h4002; DM_WDATA = 16'hCAFE;
        tick();
        tick();
        chk("abort_busy_before", BUSY, 1);
        #3 RST_N = 1'b0;
        #1;
        chk("abort_busy", BUSY, 0);
        chk("abort_regs", {MAR, MDR}, 32'h0);
        chk("abort_rdata", {IF_RDATA, DM_RDATA}, 32'h0);
        chk("abort_strobes", {LDMAR, LDMDR, LDMEM, IF_ACK, DM_ACK}, 5'b0);
        IF_REQ = 1; DM_WE = 0; MEM_RDATA = 16'hC0DE;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("abort_hold_quiet", {LDMEM, DM_ACK, IF_ACK, BUSY}, 4'b0);
        end
        RST_N = 1'b1;

        // contention: both held, expect DM, IF, DM, IF with ACKs six cycles apart
        ack_cnt = 0; ldmem_seen = 0; dual_ack = 0;
        for (int k = 1; k <= 23; k++) begin
            tick();
            if (IF_ACK && DM_ACK) dual_ack++;
            if (LDMEM) ldmem_seen++;
            if ((IF_ACK || DM_ACK) && ack_cnt < 8) begin
                ack_t[ack_cnt] = k;
                ack_p[ack_cnt] = DM_ACK;
                ack_cnt++;
            end
            if (k == 23) begin
                IF_REQ = 0; DM_REQ = 0;
            end
        end
        chk("cont_ack_count", ack_cnt, 4);
        chk("cont_ack0_time", ack_t[0], 5);
        chk("cont_ack1_time", ack_t[1], 11);
        chk("cont_ack2_time", ack_t[2], 17);
        chk("cont_ack3_time", ack_t[3], 23);
        chk("cont_order", {ack_p[0], ack_p[1], ack_p[2], ack_p[3]}, 4'b1010);
        chk("cont_no_ldmem", ldmem_seen, 0);
        chk("cont_no_dual_ack", dual_ack, 0);
        tick();
        chk("cont_idle", BUSY, 0);
        chk("cont_rdata", {IF_RDATA, DM_RDATA}, 32'hC0DE_C0DE);

        // fetch with request dropped during WAIT still completes once
        IF_REQ = 1; IF_ADDR = 16'h2222; MEM_RDATA = 16'h7777;
        tick();
        tick();
        IF_REQ = 0; IF_ADDR = 16'hFFFF;
        tick();
        tick();
        chk("drop_mar_held", MAR, 16'h2222);
        chk("drop_xfer", LDMDR, 1);
        tick();
        chk("drop_ack", IF_ACK, 1);
        chk("drop_rdata", IF_RDATA, 16'h7777);
        tick();
        chk("drop_ack_once", {IF_ACK, BUSY}, 2'b00);
        tick();
        chk("drop_no_regrant", BUSY, 0);

        // zero-wait build: DM read at 0x0010
        z_dm_req = 1; z_dm_we = 0; z_dm_addr = 16'h0010; z_mem_rdata = 16'hA5A5;
        tick();
        chk("w0_ldmar", z_ldmar, 1);
        chk("w0_mar", z_mar, 16'h0010);
        tick();
        chk("w0_xfer", {z_ldmdr, z_ldmem, z_dm_ack}, 3'b100);
        tick();
        chk("w0_ack", z_dm_ack, 1);
        chk("w0_rdata", z_dm_rdata, 16'hA5A5);
        z_dm_req = 0;
        tick();
        chk("w0_idle", {z_dm_ack, z_busy}, 2'b00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
Sequencing controller and two-port arbiter in front of the single-port RAM block. The instruction-fetch unit (IF port) and the load/store unit (DM port) share the one memory path. The controller grants one requester at a time and drives the MAR/MDR load strobes and the memory write strobe in a fixed order. It returns read data and a one-cycle acknowledge to the granted port.

Parameters:
ADDR_W, 16, address width of MAR and both request ports
DATA_W, 16, data width of MDR, write data and read data
WAIT_CYCLES, 2, memory wait states between MAR load and MDR transfer; legal range 0..15
CNT_W, 4, wait-counter width; must satisfy 2**CNT_W > WAIT_CYCLES

Ports:
CLK  in  1  single system clock, rising edge
RST_N  in  1  asynchronous active-low reset
IF_REQ  in  1  fetch read request; held high until IF_ACK
IF_ADDR  in  ADDR_W  fetch address
IF_ACK  out  1  one-cycle completion pulse for fetch
IF_RDATA  out  DATA_W  fetch read data
DM_REQ  in  1  data request; held high until DM_ACK
DM_WE  in  1  1 = write, 0 = read
DM_ADDR  in  ADDR_W  data address
DM_WDATA  in  DATA_W  data write value
DM_ACK  out  1  one-cycle completion pulse for data
DM_RDATA  out  DATA_W  data read value
MAR  out  ADDR_W  address to memory
MDR  out  DATA_W  write data to memory
LDMAR  out  1  MAR load strobe
LDMDR  out  1  MDR transfer strobe
LDMEM  out  1  memory write strobe
MEM_RDATA  in  DATA_W  memory read data; valid during XFER
BUSY  out  1  high whenever state is not IDLE

Behaviour:
- Reset (RST_N low, asynchronous) forces these values: state IDLE, wait counter 0, every output 0, and LAST_GRANT = IF. The first contended arbitration therefore goes to DM.
- If reset asserts mid-transaction, the transaction is aborted. No ACK is issued and no LDMEM pulse follows.
- The FSM is registered and has five states: IDLE, ADDR, WAIT, XFER, ACK.
- IDLE:
  - Neither request high: stay in IDLE.
  - Only one request high: grant that port.
  - Both high: grant the port that is not LAST_GRANT, then update LAST_GRANT.
  - On grant, latch address, WE (forced 0 for IF) and write data into internal registers, then go to ADDR.
- ADDR: MAR drives the latched address and LDMAR = 1 for this one cycle. Go to WAIT if WAIT_CYCLES > 0, otherwise go to XFER.
- WAIT: stay exactly WAIT_CYCLES cycles, with the counter loaded on entry and decremented each cycle. No strobes are asserted. Go to XFER when the count expires.
- XFER:
  - LDMDR = 1.
  - Write: MDR drives the latched write data and LDMEM = 1.
  - Read: LDMEM = 0 and MEM_RDATA is captured into the granted port's RDATA register at the end of this cycle.
  - Go to ACK.
- ACK: the granted port's ACK = 1 for this cycle only. Return to IDLE.
  - A new grant can occur in the next cycle, giving one idle cycle between transactions.
- Latency: a request sampled in IDLE at cycle N gives an ACK at cycle N+3+WAIT_CYCLES (N+5 at the default).
- MAR and MDR hold their last driven value between transactions. Only the strobes indicate validity.
- IF_RDATA and DM_RDATA hold their value until that port's next completed read. A DM write leaves DM_RDATA unchanged.
- A request dropped before ACK does not cancel the transaction: it completes and the ACK still pulses. A request that is still high after ACK is treated as a new request.
- Requests arriving while BUSY wait. There is no queueing beyond the held REQ level.
- Address and data are sampled only at grant. Later changes on a port's inputs during its transaction have no effect.
- There is no address arithmetic: widths pass straight through with no truncation.

Decomposition:
- Package mem_ctrl_pkg holds:
  - the state enum (IDLE, ADDR, WAIT, XFER, ACK);
  - grant encoding constants GNT_IF = 1'b0 and GNT_DM = 1'b1;
  - default width constants.
- One natural sub-module, mem_rr_arbiter: a two-way round-robin arbiter that owns LAST_GRANT. It takes inputs IF_REQ, DM_REQ and an evaluate enable (state == IDLE), and outputs grant valid and grant id. The FSM, counter and datapath registers stay in mem_access_ctrl.

Test Plan:
1. Reset: assert RST_N low mid-clock with both REQs high -> all outputs 0 immediately and BUSY = 0. After release, the first grant goes to DM.
2. Fetch read: IF_REQ = 1, IF_ADDR = 0x3000, MEM_RDATA = 0x1234 -> LDMAR at N+1 with MAR = 0x3000, LDMDR at N+4 with LDMEM = 0, IF_ACK at N+5 with IF_RDATA = 0x1234.
3. Data write: DM_REQ = 1, DM_WE = 1, DM_ADDR = 0x4001, DM_WDATA = 0xBEEF -> in XFER, LDMDR = LDMEM = 1 and MDR = 0xBEEF. DM_ACK at N+5 and DM_RDATA unchanged.
4. Contention: both REQs held continuously after reset -> grant order DM, IF, DM, IF. Each ACK is 6 cycles apart (5-cycle latency plus the idle cycle), and no port is starved.
5. WAIT_CYCLES = 0 build: a single DM read at 0x0010 -> sequence ADDR, XFER, ACK with DM_ACK at N+3.
6. Abort and drop:
   - Assert reset during WAIT -> no ACK and no LDMEM.
   - Then drop IF_REQ during WAIT of a new fetch -> the transaction still completes and IF_ACK still pulses once.
